// File: rtl/comp_sequencer_pkg.sv
// comp_seq_pkg: shared types and constants for the byte-serial comparator.
package comp_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BYTE_W = 8;
  function automatic int clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/comp_sequencer_eight_bit_comp.sv
// eight_bit_comp: one byte of a chained magnitude compare, MSB-first.
module eight_bit_comp
  import comp_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_eq_prev,
  input  logic              i_gt_prev,
  output logic              o_eq,
  output logic              o_gt
);
  assign o_eq = i_eq_prev & (i_a == i_b);
  assign o_gt = i_gt_prev | (i_eq_prev & (i_a > i_b));
endmodule

// File: rtl/comp_sequencer.sv
// comp_sequencer: multi-cycle W-bit compare built on one shared byte comparator.
module comp_sequencer
  import comp_seq_pkg::*;
#(
  parameter int NBYTES     = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                   signed_cmp,
  output logic                   busy,
  output logic                   done,
  output logic                   eq,
  output logic                   gt,
  output logic                   lt
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = clog2(NBYTES);
  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IW-1:0]   r_idx;
  logic            r_eq_acc;
  logic            r_gt_acc;
  logic            w_eq;
  logic            w_gt;
  logic            w_last;
  logic [W-1:0]    w_flip;
  // flipping the sign bit maps two's-complement onto offset binary
  assign w_flip = {signed_cmp, {(W-1){1'b0}}};
  assign w_last = (r_idx == '0) || ((EARLY_EXIT != 0) && !w_eq);
  eight_bit_comp u_comp (
    .i_a       (r_a[BYTE_W*r_idx +: BYTE_W]),
    .i_b       (r_b[BYTE_W*r_idx +: BYTE_W]),
    .i_eq_prev (r_eq_acc),
    .i_gt_prev (r_gt_acc),
    .o_eq      (w_eq),
    .o_gt      (w_gt)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_eq_acc <= 1'b1;
      r_gt_acc <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        RUN: begin
          r_eq_acc <= w_eq;
          r_gt_acc <= w_gt;
          r_idx    <= r_idx - IW'(1);
          if (w_last) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            eq      <= w_eq;
            gt      <= w_gt;
            lt      <= ~w_eq & ~w_gt;
          end
        end
        default: begin
          if (start) begin
            r_a      <= a ^ w_flip;
            r_b      <= b ^ w_flip;
            r_idx    <= IW'(NBYTES - 1);
            r_eq_acc <= 1'b1;
            r_gt_acc <= 1'b0;
            r_state  <= RUN;
            busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_comp_sequencer.sv
// tb_comp_sequencer: directed scoreboard bench for early-exit, full-run and single-byte builds.
module tb_comp_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_n1 = 1'b0;
  logic        signed_cmp = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic busy1, done1, eq1, gt1, lt1;
  logic busy0, done0, eq0, gt0, lt0;
  logic busyn, donen, eqn, gtn, ltn;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {logic [2:0] res; int cyc;} exp_t;
  typedef struct {logic [31:0] a, b; logic s; logic [2:0] res; int k1; logic [2:0] resn;} vec_t;
  exp_t q1[$], q0[$], qn[$];
  exp_t e1, e0, en;

  // res = {eq,gt,lt}; k1 = bytes consumed with early exit; resn = low-byte-only result
  vec_t vecs[9] = '{
    '{32'h12345678, 32'h12345678, 1'b0, 3'b100, 4, 3'b100},
    '{32'h80000000, 32'h00000001, 1'b0, 3'b010, 1, 3'b001},
    '{32'h80000000, 32'h00000001, 1'b1, 3'b001, 1, 3'b001},
    '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 3'b010, 4, 3'b010},
    '{32'h000000FF, 32'h000000FE, 1'b0, 3'b010, 4, 3'b010},
    '{32'h00000010, 32'h7F000000, 1'b1, 3'b001, 1, 3'b010},
    '{32'h12340000, 32'h12350000, 1'b0, 3'b001, 2, 3'b100},
    '{32'hFF000000, 32'h01000000, 1'b1, 3'b001, 1, 3'b100},
    '{32'hFF000000, 32'h01000000, 1'b0, 3'b010, 1, 3'b100}
  };

  comp_sequencer #(.NBYTES(4), .EARLY_EXIT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .signed_cmp(signed_cmp),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1));
  comp_sequencer #(.NBYTES(4), .EARLY_EXIT(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .signed_cmp(signed_cmp),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0));
  comp_sequencer #(.NBYTES(1), .EARLY_EXIT(1)) dutn (
    .clock(clock), .reset(reset), .start(start_n1), .a(a[7:0]), .b(b[7:0]), .signed_cmp(signed_cmp),
    .busy(busyn), .done(donen), .eq(eqn), .gt(gtn), .lt(ltn));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) if (done1) begin
    if (q1.size() == 0) chk("ee1 spurious done", 32'(done1), 0);
    else begin
      e1 = q1.pop_front();
      chk("ee1 result", 32'({eq1, gt1, lt1}), 32'(e1.res));
      chk("ee1 done cycle", cyc, e1.cyc);
      chk("ee1 onehot", $countones({eq1, gt1, lt1}), 1);
    end
  end
  always @(negedge clock) if (done0) begin
    if (q0.size() == 0) chk("ee0 spurious done", 32'(done0), 0);
    else begin
      e0 = q0.pop_front();
      chk("ee0 result", 32'({eq0, gt0, lt0}), 32'(e0.res));
      chk("ee0 done cycle", cyc, e0.cyc);
    end
  end
  always @(negedge clock) if (donen) begin
    if (qn.size() == 0) chk("n1 spurious done", 32'(donen), 0);
    else begin
      en = qn.pop_front();
      chk("n1 result", 32'({eqn, gtn, ltn}), 32'(en.res));
      chk("n1 done cycle", cyc, en.cyc);
    end
  end

  task automatic drain();
    for (int t = 0; t < 30 && (q1.size() + q0.size() + qn.size()) != 0; t++) @(negedge clock);
    @(negedge clock);
    chk("pending results at timeout", q1.size() + q0.size() + qn.size(), 0);
    q1.delete(); q0.delete(); qn.delete();
  endtask

  task automatic run_vec(input int i);
    int c;
    @(negedge clock);
    a = vecs[i].a; b = vecs[i].b; signed_cmp = vecs[i].s;
    start = 1'b1; start_n1 = 1'b1; c = cyc;
    q1.push_back('{vecs[i].res, c + vecs[i].k1 + 1});
    q0.push_back('{vecs[i].res, c + 5});
    qn.push_back('{vecs[i].resn, c + 2});
    @(negedge clock);
    start = 1'b0; start_n1 = 1'b0;
    chk("busy in first RUN cycle", 32'({busy1, busy0, busyn}), 32'b111);
    drain();
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clock);
    chk("ee1 reset outputs", 32'({busy1, done1, eq1, gt1, lt1}), 0);
    chk("ee0 reset outputs", 32'({busy0, done0, eq0, gt0, lt0}), 0);
    chk("n1 reset outputs", 32'({busyn, donen, eqn, gtn, ltn}), 0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) run_vec(i);
    // start pulsed mid-RUN with different operands must be ignored
    @(negedge clock);
    a = vecs[0].a; b = vecs[0].b; signed_cmp = 1'b0; start = 1'b1; c = cyc;
    q1.push_back('{3'b100, c + 5}); q0.push_back('{3'b100, c + 5});
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1; a = 32'h0; b = 32'h1;
    @(negedge clock); start = 1'b0;
    drain();
    // start held through DONE: back-to-back compares
    @(negedge clock);
    a = vecs[0].a; b = vecs[0].b; signed_cmp = 1'b0; start = 1'b1; c = cyc;
    q1.push_back('{3'b100, c + 5}); q0.push_back('{3'b100, c + 5});
    q1.push_back('{3'b010, c + 10}); q0.push_back('{3'b010, c + 10});
    @(negedge clock); a = vecs[4].a; b = vecs[4].b;
    repeat (4) @(negedge clock);
    chk("busy low in DONE", 32'({busy1, busy0}), 0);
    @(negedge clock); start = 1'b0;
    chk("busy with zero idle gap", 32'({busy1, busy0}), 32'b11);
    @(negedge clock);
    chk("results held during second RUN", 32'({eq1, gt1, lt1, eq0, gt0, lt0}), 32'b100100);
    drain();
    // reset in RUN cycle 2 abandons the compare
    @(negedge clock);
    a = vecs[4].a; b = vecs[4].b; signed_cmp = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("ee1 after mid-RUN reset", 32'({busy1, done1, eq1, gt1, lt1}), 0);
    chk("ee0 after mid-RUN reset", 32'({busy0, done0, eq0, gt0, lt0}), 0);
    repeat (8) @(negedge clock);
    run_vec(3);
    run_vec(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
